// File: rtl/reg_file.sv
// reg_file: 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file.
// Two combinational read ports and one write port that updates on the
// rising clock edge. Register 0 is hardwired to zero. An active-low
// asynchronous reset clears every register.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Every entry needs an asynchronous clear, so storage is flops rather than
  // block RAM. Entry 0 is a constant and has no storage.
  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   wsel;

  // One-hot write decode. Address 0 never selects an entry, so writes
  // there are discarded.
  always_comb begin
    wsel = '0;
    if (wen && (waddr != '0)) begin
      wsel[waddr] = 1'b1;
    end
  end

  assign regs_reg[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
      // Register gi: cleared by reset, loaded when it is the write target.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_reg[gi] <= '0;
        end else if (wsel[gi]) begin
          regs_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Combinational read ports. There is no write-through bypass, so a
  // same-cycle write shows up only after the edge that commits it.
  always_comb begin
    rdata1 = regs_reg[raddr1];
    rdata2 = regs_reg[raddr2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed table, hand sequences for reset
// behaviour, then randomized traffic checked against an array model.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mdl [32];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wen(wen), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;   // expected rdata1 before this row's edge
    logic [31:0] e2;   // expected rdata2 before this row's edge
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [31:0] mexp(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  initial begin
    // basic write/read
    tbl[0]  = '{1'b1, 5'd3,  32'h0000000A, 5'd3,  5'd17, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 5'd17, 32'hFFFFFFFF, 5'd3,  5'd17, 32'hA, 32'h0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd17, 32'hA, 32'hFFFFFFFF};
    // register 0 protection
    tbl[3]  = '{1'b1, 5'd0,  32'hCAFEF00D, 5'd0,  5'd0,  32'h0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    // write disable
    tbl[5]  = '{1'b1, 5'd8,  32'h55,       5'd8,  5'd0,  32'h0, 32'h0};
    tbl[6]  = '{1'b0, 5'd8,  32'hAA,       5'd8,  5'd8,  32'h55, 32'h55};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd3,  32'h55, 32'hA};
    // same-cycle read/write, no bypass
    tbl[8]  = '{1'b1, 5'd9,  32'h11,       5'd9,  5'd9,  32'h0, 32'h0};
    tbl[9]  = '{1'b1, 5'd9,  32'h22,       5'd9,  5'd9,  32'h11, 32'h11};
    tbl[10] = '{1'b0, 5'd9,  32'h33,       5'd9,  5'd9,  32'h22, 32'h22};
    // setup for reset clear
    tbl[11] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd5,  32'h0, 32'h0};
    tbl[12] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd31, 5'd5,  32'h12345678, 32'h0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        5'd17, 5'd8,  32'hFFFFFFFF, 32'h55};

    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd31;
    #2;
    chk("reset_state_rd1", rdata1, 32'h0);
    chk("reset_state_rd2", rdata2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 15; i++) begin
      wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      raddr1 = tbl[i].ra1; raddr2 = tbl[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rdata1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rdata2, tbl[i].e2);
      @(negedge clk);
    end

    // asynchronous reset clear between edges; write during reset is lost
    wen = 1'b1; waddr = 5'd5; wdata = 32'h77777777; raddr1 = 5'd5; raddr2 = 5'd31;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_r5", rdata1, 32'h0);
    chk("async_rst_r31", rdata2, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_dominates_write", rdata1, 32'h0);
    for (int a = 1; a < 32; a += 6) begin
      raddr1 = 5'(a);
      #1;
      chk($sformatf("rst_held_r%0d", a), rdata1, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'hA5A5A5A5; raddr1 = 5'd12; raddr2 = 5'd17;
    #1;
    chk("post_rst_pre_edge", rdata1, 32'h0);
    chk("post_rst_r17", rdata2, 32'h0);
    @(posedge clk);
    #1;
    chk("first_write_after_rst", rdata1, 32'hA5A5A5A5);

    // randomized regression against the array model
    @(negedge clk);
    rst = 1'b0; wen = 1'b0;
    for (int a = 0; a < 32; a++) mdl[a] = 32'h0;
    @(negedge clk);
    for (int s = 0; s < 200; s++) begin
      bit do_rst;
      rst = 1'b1;
      wen = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) waddr = 5'd0;
      wdata = $urandom;
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      do_rst = ($urandom_range(0, 5) == 0);
      #1;
      chk($sformatf("rnd%0d_pre_rd1", s), rdata1, mexp(raddr1));
      chk($sformatf("rnd%0d_pre_rd2", s), rdata2, mexp(raddr2));
      if (do_rst) begin
        #1;
        rst = 1'b0;
        for (int a = 0; a < 32; a++) mdl[a] = 32'h0;
        #1;
        chk($sformatf("rnd%0d_rst_rd1", s), rdata1, 32'h0);
      end
      repeat (5) begin
        @(posedge clk);
        if (rst && wen && waddr != 5'd0) mdl[waddr] = wdata;
      end
      #1;
      chk($sformatf("rnd%0d_post_rd1", s), rdata1, mexp(raddr1));
      chk($sformatf("rnd%0d_post_rd2", s), rdata2, mexp(raddr2));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
